prf_freelist: RTL and testbench

//  Physical-register free list / allocator for rename. Hands out up to 2 free PRF indices per cycle.

---
 rtl/prf_freelist.sv | 143 ++++++++++++++
 tb/tb_prf_freelist.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_freelist.sv
// Physical-register free list: 2-wide alloc, 2-wide free, flush rollback.
// Build option: FREELIST_STALL_CNT_EN adds stall_cnt_o (saturating stall count).
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   ready_o                       high once the init fill is done
//   alloc_req_i, alloc_gnt_o      thermometer request, all-or-nothing grant
//   alloc0/1_idx_o                allocated indices
//   busy0/1_idx_o, busy0/1_vld_o  status-table busy-set ports
//   free0/1_idx_i, free0/1_vld_i  released indices from commit
//   commit_alloc_i                allocating instructions committed this cycle
//   flush_i                       roll back uncommitted allocations
//   free_cnt_o                    entries available for allocation
//   stall_cnt_o                   (FREELIST_STALL_CNT_EN only) stall cycles
module prf_freelist #(
  parameter int PREGS = 64,
  parameter int ARCH  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic                       ready_o,
  input  logic [1:0]                 alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [$clog2(PREGS)-1:0]   alloc0_idx_o,
  output logic [$clog2(PREGS)-1:0]   alloc1_idx_o,
  output logic [$clog2(PREGS)-1:0]   busy0_idx_o,
  output logic                       busy0_vld_o,
  output logic [$clog2(PREGS)-1:0]   busy1_idx_o,
  output logic                       busy1_vld_o,
  input  logic [$clog2(PREGS)-1:0]   free0_idx_i,
  input  logic                       free0_vld_i,
  input  logic [$clog2(PREGS)-1:0]   free1_idx_i,
  input  logic                       free1_vld_i,
  input  logic [1:0]                 commit_alloc_i,
  input  logic                       flush_i,
  output logic [$clog2(PREGS):0]     free_cnt_o
`ifdef FREELIST_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt_o
`endif
);

  localparam int IW    = $clog2(PREGS);
  localparam int PW    = IW + 1;
  localparam int NINIT = PREGS - ARCH;
  localparam int CW    = $clog2(NINIT);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   init_q;
  logic [PW-1:0]   wr_q, srd_q, crd_q;
  logic [IW-1:0]   mem [PREGS];

  logic            init_last;
  logic [1:0]      n_req;
  logic            v0, v1;
  logic [PW-1:0]   wr_p1, srd_p1;
  logic [PW-1:0]   n_free;

  assign init_last = (init_q == CW'(NINIT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: if (init_last) state_d = S_RUN;
      S_RUN:  state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign ready_o    = (state_q == S_RUN);
  assign free_cnt_o = wr_q - srd_q;
  assign n_req      = {1'b0, alloc_req_i[0]} + {1'b0, alloc_req_i[1]};

  assign alloc_gnt_o = ready_o & ~flush_i & (|alloc_req_i)
                     & (free_cnt_o >= PW'(n_req));

  assign srd_p1       = srd_q + PW'(1);
  assign alloc0_idx_o = mem[srd_q[IW-1:0]];
  assign alloc1_idx_o = mem[srd_p1[IW-1:0]];

  assign busy0_idx_o = alloc0_idx_o;
  assign busy1_idx_o = alloc1_idx_o;
  assign busy0_vld_o = alloc_gnt_o & alloc_req_i[0];
  assign busy1_vld_o = alloc_gnt_o & alloc_req_i[1];

  // p0 is the hardwired zero register and must never reenter the list
  assign v0     = ready_o & free0_vld_i & (|free0_idx_i);
  assign v1     = ready_o & free1_vld_i & (|free1_idx_i);
  assign wr_p1  = wr_q + PW'(v0);
  assign n_free = PW'(v0) + PW'(v1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      init_q  <= '0;
      wr_q    <= '0;
      srd_q   <= '0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        init_q <= init_q + CW'(1);
        if (init_last) wr_q <= PW'(NINIT);
      end else begin
        wr_q  <= wr_q + n_free;
        crd_q <= crd_q + PW'(commit_alloc_i);
        // same-cycle commits are retired before the rollback point is taken
        if (flush_i)
          srd_q <= crd_q + PW'(commit_alloc_i);
        else if (alloc_gnt_o)
          srd_q <= srd_q + PW'(n_req);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == S_INIT) begin
        mem[IW'(init_q)] <= IW'(ARCH) + IW'(init_q);
      end else begin
        if (v0) mem[wr_q[IW-1:0]]  <= free0_idx_i;
        if (v1) mem[wr_p1[IW-1:0]] <= free1_idx_i;
      end
    end
  end

`ifdef FREELIST_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      stall_q <= '0;
    else if (ready_o & (|alloc_req_i) & ~flush_i
             & ~alloc_gnt_o & ~(&stall_q))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_prf_freelist.sv
// Testbench for prf_freelist: queue-based reference model, scoreboard monitor.
// Directed rename scenarios followed by randomized alloc/free/commit/flush.
module tb_prf_freelist;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ready_o;
  logic [1:0] alloc_req_i;
  logic       alloc_gnt_o;
  logic [5:0] alloc0_idx_o, alloc1_idx_o;
  logic [5:0] busy0_idx_o, busy1_idx_o;
  logic       busy0_vld_o, busy1_vld_o;
  logic [5:0] free0_idx_i, free1_idx_i;
  logic       free0_vld_i, free1_vld_i;
  logic [1:0] commit_alloc_i;
  logic       flush_i;
  logic [6:0] free_cnt_o;

  always #5 clk_i = ~clk_i;

  prf_freelist dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ready_o(ready_o),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc0_idx_o(alloc0_idx_o), .alloc1_idx_o(alloc1_idx_o),
    .busy0_idx_o(busy0_idx_o), .busy0_vld_o(busy0_vld_o),
    .busy1_idx_o(busy1_idx_o), .busy1_vld_o(busy1_vld_o),
    .free0_idx_i(free0_idx_i), .free0_vld_i(free0_vld_i),
    .free1_idx_i(free1_idx_i), .free1_vld_i(free1_vld_i),
    .commit_alloc_i(commit_alloc_i), .flush_i(flush_i),
    .free_cnt_o(free_cnt_o)
  );

  typedef struct {
    bit       gnt;
    bit [1:0] req;
    int       i0;
    int       i1;
    int       fc;
  } exp_t;

  exp_t exp_q[$];
  int   avail[$];
  int   infl[$];
  int   owned[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", 32'(alloc_gnt_o), 32'(e.gnt));
        chk("free_cnt", 32'(free_cnt_o), e.fc);
        chk("busy0_vld", 32'(busy0_vld_o), 32'(e.gnt & e.req[0]));
        chk("busy1_vld", 32'(busy1_vld_o), 32'(e.gnt & e.req[1]));
        if (e.gnt) begin
          chk("idx0", 32'(alloc0_idx_o), e.i0);
          chk("busy0_idx", 32'(busy0_idx_o), e.i0);
          if (e.req[1]) begin
            chk("idx1", 32'(alloc1_idx_o), e.i1);
            chk("busy1_idx", 32'(busy1_idx_o), e.i1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    avail.delete();
    infl.delete();
    owned.delete();
    for (int i = 32; i < 64; i++) avail.push_back(i);
    for (int i = 1; i < 32; i++) owned.push_back(i);
  endtask

  task automatic take(output int v);
    int k;
    k = $urandom_range(owned.size() - 1);
    v = owned[k];
    owned.delete(k);
  endtask

  task automatic step(input logic [1:0] req, input bit f0v, input int f0,
                      input bit f1v, input int f1, input int cmt,
                      input bit fl);
    exp_t e;
    int   n;
    @(posedge clk_i);
    #1;
    alloc_req_i    = req;
    free0_vld_i    = f0v;
    free0_idx_i    = 6'(f0);
    free1_vld_i    = f1v;
    free1_idx_i    = 6'(f1);
    commit_alloc_i = 2'(cmt);
    flush_i        = fl;
    n = int'(req[0]) + int'(req[1]);
    e.req = req;
    e.fc  = avail.size();
    e.gnt = !fl && n > 0 && avail.size() >= n;
    e.i0  = avail.size() > 0 ? avail[0] : 0;
    e.i1  = avail.size() > 1 ? avail[1] : 0;
    exp_q.push_back(e);
    for (int k = 0; k < cmt; k++) owned.push_back(infl.pop_front());
    if (fl) begin
      while (infl.size() > 0) avail.push_front(infl.pop_back());
    end else if (e.gnt) begin
      for (int k = 0; k < n; k++) infl.push_back(avail.pop_front());
    end
    if (f0v && f0 != 0) avail.push_back(f0);
    if (f1v && f1 != 0) avail.push_back(f1);
  endtask

  task automatic idle_in();
    alloc_req_i    = 2'b00;
    free0_vld_i    = 1'b0;
    free0_idx_i    = '0;
    free1_vld_i    = 1'b0;
    free1_idx_i    = '0;
    commit_alloc_i = 2'd0;
    flush_i        = 1'b0;
  endtask

  task automatic release_and_init();
    int cyc;
    @(posedge clk_i);
    #1;
    idle_in();
    rst_ni = 1'b1;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("init_cycles", cyc, 32);
  endtask

  initial begin : main
    int v, r, f0, f1, cm;
    bit f0v, f1v, fl;
    logic [1:0] rq;

    idle_in();
    alloc_req_i = 2'b11;
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_gnt", 32'(alloc_gnt_o), 0);
    chk("rst_busy0", 32'(busy0_vld_o), 0);
    chk("rst_busy1", 32'(busy1_vld_o), 0);
    release_and_init();

    // first pair is 32,33; then exhaust the list
    for (int i = 0; i < 16; i++) step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0, 0, 0);

    // one entry left: pair refused, single granted
    take(v);
    step(2'b00, 1, v, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0, 0, 0);

    // reset while allocations are in flight
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    alloc_req_i = 2'b11;
    @(posedge clk_i);
    #1;
    chk("mid_rst_ready", 32'(ready_o), 0);
    chk("mid_rst_gnt", 32'(alloc_gnt_o), 0);
    chk("mid_rst_busy0", 32'(busy0_vld_o), 0);
    chk("mid_rst_busy1", 32'(busy1_vld_o), 0);
    model_reset();
    release_and_init();

    // allocate 6, commit 2 with flush, reallocate from 34
    repeat (3) step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 2, 1);
    step(2'b01, 0, 0, 0, 0, 0, 0);

    // free 5 plus a zero index, then drain
    foreach (owned[i]) if (owned[i] == 5) begin
      owned.delete(i);
      break;
    end
    step(2'b00, 1, 5, 1, 0, 0, 0);
    while (avail.size() > 0)
      step(avail.size() >= 2 ? 2'b11 : 2'b01, 0, 0, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(2);
      rq = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      cm = $urandom_range(infl.size() < 2 ? infl.size() : 2);
      fl = ($urandom_range(15) == 0);
      f0v = 0; f0 = 0; f1v = 0; f1 = 0;
      if ($urandom_range(19) == 0) f0v = 1;
      else if (owned.size() > 0 && $urandom_range(2) == 0) begin
        take(f0);
        f0v = 1;
      end
      if ($urandom_range(19) == 0) f1v = 1;
      else if (owned.size() > 0 && $urandom_range(2) == 0) begin
        take(f1);
        f1v = 1;
      end
      step(rq, f0v, f0, f1v, f1, cm, fl);
    end

    @(posedge clk_i);
    #1;
    idle_in();
    @(negedge clk_i);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
